// File: rtl/count_seq_ctrl_pkg.sv
// Shared encodings for the command-driven up/down count sequencer.
package count_seq_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_UP    = 2'b01,
        OP_DOWN  = 2'b10,
        OP_GOTO  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/count_step_core.sv
// Count register that moves one step per enabled clock, wrapping or clamping
// at the bounds depending on WRAP.
module count_step_core
    import count_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en,
    input  logic             updown,
    input  logic             clear_en,
    output logic [WIDTH-1:0] count,
    output logic             clamp
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             w_at_bound;

    assign w_at_bound = updown ? (r_count == MAX_VAL) : (r_count == '0);
    // In saturating mode a step that would leave the range is swallowed.
    assign clamp      = step_en & ~WRAP & w_at_bound;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear_en) begin
            r_count <= '0;
        end else if (step_en && !clamp) begin
            r_count <= updown ? (r_count + ONE) : (r_count - ONE);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/count_seq_ctrl.sv
// Accepts clear / step-up / step-down / goto commands over valid/ready and
// drives the count core one step per clock, pulsing done on completion.
module count_seq_ctrl
    import count_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic [WIDTH-1:0] count,
    output logic             updown,
    output logic             busy,
    output logic             done,
    output logic             sat
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           r_state;
    state_e           w_state_next;
    op_e              r_op;
    logic [WIDTH-1:0] r_remaining;
    logic             r_updown;
    logic             r_sat;

    op_e              w_op;
    logic             w_accept;
    logic             w_goto_up;
    logic [WIDTH-1:0] w_goto_dist;
    logic [WIDTH-1:0] w_rem_init;
    logic [WIDTH-1:0] w_count;
    logic             w_clamp;
    logic             w_step_en;
    logic             w_clear_en;

    assign w_op        = op_e'(cmd_op);
    assign w_accept    = cmd_valid & cmd_ready;
    assign w_goto_up   = (cmd_arg > w_count);
    assign w_goto_dist = w_goto_up ? (cmd_arg - w_count) : (w_count - cmd_arg);
    assign w_step_en   = (r_state == S_RUN);
    assign w_clear_en  = w_accept & (w_op == OP_CLEAR);

    always_comb begin
        w_rem_init = '0;
        case (w_op)
            OP_UP, OP_DOWN: w_rem_init = cmd_arg;
            OP_GOTO:        w_rem_init = w_goto_dist;
            default:        w_rem_init = '0;
        endcase
    end

    count_step_core #(
        .WIDTH (WIDTH),
        .WRAP  (WRAP)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .step_en  (w_step_en),
        .updown   (r_updown),
        .clear_en (w_clear_en),
        .count    (w_count),
        .clamp    (w_clamp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_rem_init == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_remaining == ONE) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        busy      = (r_state == S_RUN);
        done      = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op        <= OP_CLEAR;
            r_remaining <= '0;
            r_updown    <= 1'b1;
            r_sat       <= 1'b0;
        end else if (w_accept) begin
            r_op        <= w_op;
            r_remaining <= w_rem_init;
            r_sat       <= 1'b0;
            case (w_op)
                OP_UP:   r_updown <= 1'b1;
                OP_DOWN: r_updown <= 1'b0;
                OP_GOTO: r_updown <= w_goto_up;
                default: r_updown <= r_updown;
            endcase
        end else if (r_state == S_RUN) begin
            r_remaining <= r_remaining - ONE;
            // GOTO travels inside the range, so it can never legitimately clamp.
            if (w_clamp && (r_op != OP_GOTO)) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign count  = w_count;
    assign updown = r_updown;
    assign sat    = r_sat;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Randomized and directed checks of count_seq_ctrl in wrapping and saturating
// builds against a per-command trajectory model.
module tb_count_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [4:0] cmd_arg;

    logic       valid_w, valid_s;
    logic       ready_w, ready_s;
    logic [4:0] count_w, count_s;
    logic       updown_w, updown_s, busy_w, busy_s, done_w, done_s, sat_w, sat_s;

    logic       o_ready, o_updown, o_busy, o_done, o_sat;
    logic [4:0] o_count;

    int checks = 0;
    int errors = 0;
    int m_count [2];
    bit m_updown[2];
    bit m_sat   [2];

    assign valid_w  = cmd_valid & sel;
    assign valid_s  = cmd_valid & ~sel;
    assign o_ready  = sel ? ready_w  : ready_s;
    assign o_count  = sel ? count_w  : count_s;
    assign o_updown = sel ? updown_w : updown_s;
    assign o_busy   = sel ? busy_w   : busy_s;
    assign o_done   = sel ? done_w   : done_s;
    assign o_sat    = sel ? sat_w    : sat_s;

    count_seq_ctrl #(.WIDTH(5), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .cmd_valid(valid_w), .cmd_ready(ready_w),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .count(count_w), .updown(updown_w),
        .busy(busy_w), .done(done_w), .sat(sat_w)
    );

    count_seq_ctrl #(.WIDTH(5), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .cmd_valid(valid_s), .cmd_ready(ready_s),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .count(count_s), .updown(updown_s),
        .busy(busy_s), .done(done_s), .sat(sat_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Position after k steps from c0, wrapped mod 32 or clamped to [0,31].
    function automatic int exp_count(int c0, int k, bit up, bit wrap);
        int v;
        v = up ? c0 + k : c0 - k;
        if (wrap) return ((v % 32) + 32) % 32;
        if (v > 31) return 31;
        if (v < 0) return 0;
        return v;
    endfunction

    function automatic bit exp_sat(int c0, int k, bit up, bit wrap);
        int v;
        v = up ? c0 + k : c0 - k;
        return !wrap && (v > 31 || v < 0);
    endfunction

    task automatic run_cmd(input logic [1:0] op, input int arg, input bit hold);
        int  w, c0, n, fin, e;
        bit  up, wrap, is_goto, es;
        w       = sel ? 1 : 0;
        wrap    = sel;
        c0      = m_count[w];
        up      = m_updown[w];
        is_goto = (op == 2'b11);
        n       = 0;
        case (op)
            2'b00: n = 0;
            2'b01: begin up = 1'b1; n = arg; end
            2'b10: begin up = 1'b0; n = arg; end
            default: begin up = (arg > c0); n = up ? arg - c0 : c0 - arg; end
        endcase
        fin = (op == 2'b00) ? 0 : exp_count(c0, n, up, wrap);

        @(negedge clk);
        if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_idle got %0b want 1", o_ready); end
        checks++;
        if (o_sat !== m_sat[w]) begin errors++; $display("FAIL sat_hold got %0b want %0b", o_sat, m_sat[w]); end
        checks++;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = 5'(arg);

        @(negedge clk);
        if (hold) begin cmd_op = 2'($urandom_range(0, 3)); cmd_arg = 5'($urandom_range(0, 31)); end
        else cmd_valid = 1'b0;
        e = (n == 0) ? fin : c0;
        if (o_count !== 5'(e)) begin errors++; $display("FAIL accept_count got %0d want %0d", o_count, e); end
        checks++;
        if (o_busy !== (n > 0) || o_done !== (n == 0) || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_flags got busy %0b done %0b ready %0b want busy %0b done %0b ready 0",
                     o_busy, o_done, o_ready, n > 0, n == 0);
        end
        checks++;
        if (o_updown !== up || o_sat !== 1'b0) begin
            errors++; $display("FAIL accept_dir got updown %0b sat %0b want %0b 0", o_updown, o_sat, up);
        end
        checks++;

        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (hold) begin cmd_op = 2'($urandom_range(0, 3)); cmd_arg = 5'($urandom_range(0, 31)); end
            e  = exp_count(c0, k, up, wrap);
            es = is_goto ? 1'b0 : exp_sat(c0, k, up, wrap);
            if (o_count !== 5'(e)) begin errors++; $display("FAIL step_count k=%0d got %0d want %0d", k, o_count, e); end
            checks++;
            if (o_busy !== (k < n) || o_done !== (k == n) || o_sat !== es) begin
                errors++;
                $display("FAIL step_flags k=%0d got busy %0b done %0b sat %0b want %0b %0b %0b",
                         k, o_busy, o_done, o_sat, k < n, k == n, es);
            end
            checks++;
        end

        @(negedge clk);
        cmd_valid = 1'b0;
        if (o_ready !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b0 || o_count !== 5'(fin)) begin
            errors++;
            $display("FAIL back_idle got ready %0b done %0b busy %0b count %0d want 1 0 0 %0d",
                     o_ready, o_done, o_busy, o_count, fin);
        end
        checks++;

        m_count[w]  = fin;
        m_updown[w] = up;
        m_sat[w]    = is_goto ? 1'b0 : exp_sat(c0, n, up, wrap);
        $display("cmd dut_wrap=%0d op=%0d arg=%0d hold=%0b steps=%0d count %0d -> %0d sat=%0b",
                 w, op, arg, hold, n, c0, fin, m_sat[w]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_count[i] = 0; m_updown[i] = 1'b1; m_sat[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0; sel = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = (i == 1);
            #1;
            if (o_ready !== 1'b1 || o_count !== 5'd0 || o_updown !== 1'b1 ||
                o_busy !== 1'b0 || o_done !== 1'b0 || o_sat !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d got ready %0b count %0d updown %0b busy %0b done %0b sat %0b want 1 0 1 0 0 0",
                         i, o_ready, o_count, o_updown, o_busy, o_done, o_sat);
            end
            checks++;
        end
        $display("reset released, both instances idle");
    endtask

    task automatic test_directed();
        sel = 1'b1;
        run_cmd(2'b01, 3, 1'b0);
        run_cmd(2'b11, 30, 1'b0);
        run_cmd(2'b01, 4, 1'b0);
        run_cmd(2'b11, 1, 1'b0);
        run_cmd(2'b10, 3, 1'b0);
        sel = 1'b0;
        run_cmd(2'b11, 29, 1'b0);
        run_cmd(2'b01, 5, 1'b0);
        run_cmd(2'b10, 0, 1'b0);
        run_cmd(2'b11, 12, 1'b0);
        run_cmd(2'b11, 7, 1'b0);
        run_cmd(2'b11, 12, 1'b0);
        run_cmd(2'b11, 12, 1'b0);
        run_cmd(2'b10, 14, 1'b0);
        run_cmd(2'b00, 9, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        run_cmd(2'b01, 6, 1'b1);
        run_cmd(2'b10, 9, 1'b1);
        sel = 1'b0;
        run_cmd(2'b11, 20, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom_range(0, 1));
            run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic test_reset_mid_run();
        sel = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 5'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        if (count_w !== 5'd0 || count_s !== 5'd0 || busy_w !== 1'b0 || done_w !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got count %0d/%0d busy %0b done %0b want 0/0 0 0",
                     count_w, count_s, busy_w, done_w);
        end
        checks++;
        @(negedge clk);
        if (done_w !== 1'b0 || busy_w !== 1'b0) begin
            errors++; $display("FAIL reset_hold got done %0b busy %0b want 0 0", done_w, busy_w);
        end
        checks++;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        if (ready_w !== 1'b1 || done_w !== 1'b0 || updown_w !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got ready %0b done %0b updown %0b want 1 0 1", ready_w, done_w, updown_w);
        end
        checks++;
        $display("reset asserted mid-run, command aborted");
        run_cmd(2'b00, 0, 1'b0);
        run_cmd(2'b01, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
Command-driven sequencer for the 5-bit up/down count datapath. Accepts one command at a time over a valid/ready handshake: clear, step up N, step down N, or go to a target value. Steps the counter one count per clock and reports completion. Sits between the control logic and the counter, replacing direct toggling of updown/rst.

Parameters:
WIDTH, 5, counter and argument width
WRAP, 1, 1 = modular wrap at 0/2^WIDTH-1; 0 = saturate at the bounds

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  2  00 CLEAR, 01 UP, 10 DOWN, 11 GOTO
cmd_arg  input  WIDTH  step count for UP/DOWN; target for GOTO; ignored for CLEAR
count  output  WIDTH  current counter value
updown  output  1  direction of the current or last step: 1 up, 0 down
busy  output  1  high in RUN
done  output  1  one-cycle completion pulse
sat  output  1  saturation hit during the current or last command (WRAP=0 only)

Behaviour:
- Reset (rst low, asynchronous): state IDLE, count 0, remaining 0, updown 1, busy 0, done 0, sat 0. After release, cmd_ready=1.
- Reset mid-command aborts it. No done pulse is produced, and the command is lost.
- FSM states: IDLE, RUN, DONE.
  - cmd_ready = (state==IDLE).
  - Accept = cmd_valid & cmd_ready, sampled on the edge. cmd_valid while not ready is ignored; the controller does not queue.
- On the accept edge:
  - Latch op. Clear sat.
  - CLEAR: count<=0, go DONE.
  - UP: updown<=1, remaining<=cmd_arg.
  - DOWN: updown<=0, remaining<=cmd_arg.
  - GOTO: updown<=(cmd_arg>count), remaining<=|cmd_arg-count| (unsigned compare, no wrap path).
  - If remaining would be 0: go DONE directly; count unchanged.
  - Otherwise go RUN.
- In RUN, each edge:
  - count<=count±1 per updown; remaining<=remaining-1.
  - When remaining reaches 0 on this edge, go DONE.
- Step latency: N steps for an arg of N, the first at the edge after accept.
- DONE lasts exactly one cycle: done=1, cmd_ready=0. Next edge returns to IDLE.
- Wrap/saturation:
  - WRAP=1: 31+1 -> 0 and 0-1 -> 31, arithmetic mod 2^WIDTH.
  - WRAP=0: count holds at 31 on UP or 0 on DOWN. Remaining steps are still consumed (fixed duration). sat<=1 on the first clamped step and stays high until the next accept.
- GOTO never wraps or saturates.
- busy=1 exactly in RUN. done and busy are never high together.
- Total command duration from accept edge to IDLE: N+2 edges for N>0; 2 edges for N=0 or CLEAR.

Decomposition:
- Shared package: cmd_op encodings (OP_CLEAR, OP_UP, OP_DOWN, OP_GOTO), FSM state encodings (S_IDLE, S_RUN, S_DONE), default WIDTH.
- One natural sub-module, count_step_core:
  - Holds the WIDTH-bit count register.
  - Inputs: step_en, updown, clear_en, WRAP.
  - Outputs: count, the clamp indication.
- The FSM and remaining counter stay in count_seq_ctrl.

Test Plan:
- Reset then UP arg=3 from 0 -> count 1,2,3 on the three edges after accept; done high the following cycle; cmd_ready back high one cycle later; busy high for exactly 3 cycles.
- WRAP=1, count=30, UP arg=4 -> count 31,0,1,2; sat stays 0. DOWN arg=3 from 1 -> 0,31,30.
- WRAP=0, count=29, UP arg=5 -> 30,31,31,31,31; sat=1 from the third step until the next accept; done after 5 steps.
- GOTO arg=7 from 12 -> updown=0, count 11..7 in 5 steps. GOTO arg=12 from 12 -> no step; done on the cycle after accept.
- cmd_valid held high through RUN with changing cmd_arg -> only the IDLE-cycle command is accepted; the next accept happens only when cmd_ready=1.
- rst driven low mid-RUN between clock edges -> count=0, busy=0, no done pulse, cmd_ready=1 after release; a subsequent CLEAR completes in 2 edges.
